// File: rtl/int_bypass_network_pkg.sv
// Shared types and constants for the integer operand-forwarding network.
package int_bypass_network_pkg;

    // Core datapath width; the forwarding slots carry full-width results.
    localparam int unsigned CORE_XLEN = 32;

    // Architectural zero register: never forwarded, never committed.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One in-flight writeback.
    typedef struct packed {
        logic                 valid;
        logic [4:0]           rd;
        logic                 dvalid;
        logic [CORE_XLEN-1:0] data;
    } bypass_slot_t;

endpackage

// File: rtl/int_bypass_network_lookup.sv
// Single-port youngest-match lookup over the flattened in-flight slot array.
module int_bypass_network_lookup
    import int_bypass_network_pkg::*;
#(
    parameter int unsigned XLEN       = CORE_XLEN,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LATE_STAGE = 1
) (
    input  logic [DEPTH-1:0]      slot_valid_i,
    input  logic [DEPTH*5-1:0]    slot_rd_i,
    input  logic [DEPTH-1:0]      slot_dvalid_i,
    input  logic [DEPTH*XLEN-1:0] slot_data_i,
    input  logic [4:0]            rd_sel_i,
    input  logic                  late_valid_i,
    input  logic [XLEN-1:0]       late_data_i,
    output logic                  hit_o,
    output logic                  pending_o,
    output logic [XLEN-1:0]       data_o
);

    // Walk oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        hit_o     = 1'b0;
        pending_o = 1'b0;
        data_o    = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (rd_sel_i != REG_ZERO && slot_valid_i[i] && slot_rd_i[i*5 +: 5] == rd_sel_i) begin
                hit_o = 1'b1;
                if (slot_dvalid_i[i]) begin
                    pending_o = 1'b0;
                    data_o    = slot_data_i[i*XLEN +: XLEN];
                end else if (i == int'(LATE_STAGE) && late_valid_i) begin
                    // Late result arriving this cycle is bypassed straight through.
                    pending_o = 1'b0;
                    data_o    = late_data_i;
                end else begin
                    pending_o = 1'b1;
                    data_o    = '0;
                end
            end
        end
    end

endmodule

// File: rtl/int_bypass_network.sv
// Integer operand-forwarding network: a DEPTH-slot shift register of in-flight
// writebacks with per-port youngest-match lookup and commit from the oldest slot.
module int_bypass_network
    import int_bypass_network_pkg::*;
#(
    parameter int unsigned XLEN       = CORE_XLEN,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned READ_PORTS = 2,
    parameter int unsigned LATE_STAGE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [4:0]                 in_rd_i,
    input  logic                       in_data_valid_i,
    input  logic [XLEN-1:0]            in_data_i,
    input  logic                       late_valid_i,
    input  logic [XLEN-1:0]            late_data_i,
    input  logic [READ_PORTS*5-1:0]    rd_sel_i,
    output logic [READ_PORTS-1:0]      fwd_hit_o,
    output logic [READ_PORTS-1:0]      fwd_pending_o,
    output logic [READ_PORTS*XLEN-1:0] fwd_data_o,
    output logic                       commit_valid_o,
    output logic [4:0]                 commit_rd_o,
    output logic [XLEN-1:0]            commit_data_o
);

    bypass_slot_t slot_q    [DEPTH];
    bypass_slot_t slot_d    [DEPTH];
    bypass_slot_t slot_fill [DEPTH];

    logic late_fill;

    logic [DEPTH-1:0]      slot_valid;
    logic [DEPTH-1:0]      slot_dvalid;
    logic [DEPTH*5-1:0]    slot_rd;
    logic [DEPTH*XLEN-1:0] slot_data;

    // A late result only lands on a valid entry that is still waiting for data.
    assign late_fill = late_valid_i && slot_q[LATE_STAGE].valid && !slot_q[LATE_STAGE].dvalid;

    // Current slots with the late result merged in, before any shift.
    always_comb begin
        slot_fill = slot_q;
        if (late_fill) begin
            slot_fill[LATE_STAGE].dvalid = 1'b1;
            slot_fill[LATE_STAGE].data   = late_data_i;
        end
    end

    // Next-state: flush wins, otherwise shift on advance, otherwise hold.
    always_comb begin
        slot_d = slot_fill;
        if (flush_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_d[i].valid  = 1'b0;
                slot_d[i].dvalid = 1'b0;
            end
        end else if (advance_i) begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                slot_d[i] = slot_fill[i-1];
            end
            slot_d[0].valid  = in_valid_i && (in_rd_i != REG_ZERO);
            slot_d[0].rd     = in_rd_i;
            slot_d[0].dvalid = in_data_valid_i;
            slot_d[0].data   = in_data_i;
        end
    end

    // Slot storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

    // Flatten the slot array for the per-port lookup instances.
    always_comb begin
        slot_valid  = '0;
        slot_dvalid = '0;
        slot_rd     = '0;
        slot_data   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_valid[i]              = slot_q[i].valid;
            slot_dvalid[i]             = slot_q[i].dvalid;
            slot_rd[i*5 +: 5]          = slot_q[i].rd;
            slot_data[i*XLEN +: XLEN]  = slot_q[i].data;
        end
    end

    // The retiring entry still commits in a flush cycle.
    assign commit_valid_o = advance_i && slot_q[DEPTH-1].valid;
    assign commit_rd_o    = commit_valid_o ? slot_q[DEPTH-1].rd   : '0;
    assign commit_data_o  = commit_valid_o ? slot_q[DEPTH-1].data : '0;

    for (genvar p = 0; p < int'(READ_PORTS); p++) begin : g_port
        int_bypass_network_lookup #(
            .XLEN       (XLEN),
            .DEPTH      (DEPTH),
            .LATE_STAGE (LATE_STAGE)
        ) u_lookup (
            .slot_valid_i  (slot_valid),
            .slot_rd_i     (slot_rd),
            .slot_dvalid_i (slot_dvalid),
            .slot_data_i   (slot_data),
            .rd_sel_i      (rd_sel_i[p*5 +: 5]),
            .late_valid_i  (late_valid_i),
            .late_data_i   (late_data_i),
            .hit_o         (fwd_hit_o[p]),
            .pending_o     (fwd_pending_o[p]),
            .data_o        (fwd_data_o[p*XLEN +: XLEN])
        );
    end

    // A late result must target a valid entry that has no data yet.
    late_target_ok: assert property (@(posedge clk) disable iff (rst)
        late_valid_i |-> (slot_q[LATE_STAGE].valid && !slot_q[LATE_STAGE].dvalid));

    // Anything reaching the commit slot must already hold its result.
    commit_has_data: assert property (@(posedge clk) disable iff (rst)
        slot_q[DEPTH-1].valid |-> slot_q[DEPTH-1].dvalid);

endmodule

// File: tb/tb_int_bypass_network.sv
// Bench for int_bypass_network: directed vector table, reset/sweep sequences and
// a randomized run against a slot-array reference model.
module tb_int_bypass_network;

    localparam int D = 3;
    localparam int L = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: default configuration
    logic        a_adv, a_fl, a_iv, a_idv, a_lv;
    logic [4:0]  a_ird;
    logic [31:0] a_idata, a_ldata;
    logic [9:0]  a_sel;
    logic [1:0]  a_hit, a_pend;
    logic [63:0] a_fdata;
    logic        a_cv;
    logic [4:0]  a_crd;
    logic [31:0] a_cdata;

    // DUT B: DEPTH=4, READ_PORTS=3, LATE_STAGE=2
    logic        b_adv, b_fl, b_iv, b_idv, b_lv;
    logic [4:0]  b_ird;
    logic [31:0] b_idata, b_ldata;
    logic [14:0] b_sel;
    logic [2:0]  b_hit, b_pend;
    logic [95:0] b_fdata;
    logic        b_cv;
    logic [4:0]  b_crd;
    logic [31:0] b_cdata;

    int_bypass_network #(.XLEN(32), .DEPTH(3), .READ_PORTS(2), .LATE_STAGE(1)) u_dut_a (
        .clk(clk), .rst(rst), .advance_i(a_adv), .flush_i(a_fl), .in_valid_i(a_iv),
        .in_rd_i(a_ird), .in_data_valid_i(a_idv), .in_data_i(a_idata),
        .late_valid_i(a_lv), .late_data_i(a_ldata), .rd_sel_i(a_sel),
        .fwd_hit_o(a_hit), .fwd_pending_o(a_pend), .fwd_data_o(a_fdata),
        .commit_valid_o(a_cv), .commit_rd_o(a_crd), .commit_data_o(a_cdata)
    );

    int_bypass_network #(.XLEN(32), .DEPTH(4), .READ_PORTS(3), .LATE_STAGE(2)) u_dut_b (
        .clk(clk), .rst(rst), .advance_i(b_adv), .flush_i(b_fl), .in_valid_i(b_iv),
        .in_rd_i(b_ird), .in_data_valid_i(b_idv), .in_data_i(b_idata),
        .late_valid_i(b_lv), .late_data_i(b_ldata), .rd_sel_i(b_sel),
        .fwd_hit_o(b_hit), .fwd_pending_o(b_pend), .fwd_data_o(b_fdata),
        .commit_valid_o(b_cv), .commit_rd_o(b_crd), .commit_data_o(b_cdata)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        adv, fl, iv;
        logic [4:0]  ird;
        logic        idv;
        logic [31:0] idata;
        logic        lv;
        logic [31:0] ldata;
        logic [4:0]  s0, s1;
        logic [1:0]  hit, pend;
        logic [31:0] d0, d1;
        logic        cv;
        logic [4:0]  crd;
        logic [31:0] cdata;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t row(
        input logic adv, fl, iv, input logic [4:0] ird, input logic idv,
        input logic [31:0] idata, input logic lv, input logic [31:0] ldata,
        input logic [4:0] s0, s1, input logic [1:0] hit, pend,
        input logic [31:0] d0, d1, input logic cv, input logic [4:0] crd,
        input logic [31:0] cdata);
        vec_t v;
        v.adv = adv; v.fl = fl; v.iv = iv; v.ird = ird; v.idv = idv; v.idata = idata;
        v.lv = lv; v.ldata = ldata; v.s0 = s0; v.s1 = s1; v.hit = hit; v.pend = pend;
        v.d0 = d0; v.d1 = d1; v.cv = cv; v.crd = crd; v.cdata = cdata;
        return v;
    endfunction

    task automatic drive_a(input logic adv, fl, iv, input logic [4:0] ird, input logic idv,
                           input logic [31:0] idata, input logic lv,
                           input logic [31:0] ldata, input logic [4:0] s0, s1);
        a_adv = adv; a_fl = fl; a_iv = iv; a_ird = ird; a_idv = idv; a_idata = idata;
        a_lv = lv; a_ldata = ldata; a_sel = {s1, s0};
    endtask

    // Reference model: entries indexed by age, 0 = youngest.
    logic        mv  [D];
    logic [4:0]  mrd [D];
    logic        mdv [D];
    logic [31:0] md  [D];

    function automatic logic [33:0] model_port(input logic [4:0] sel, input logic lv,
                                               input logic [31:0] ld);
        for (int i = 0; i < D; i++) begin
            if (sel != 5'd0 && mv[i] && mrd[i] == sel) begin
                if (mdv[i]) return {1'b1, 1'b0, md[i]};
                if (i == L && lv) return {1'b1, 1'b0, ld};
                return {1'b1, 1'b1, 32'h0};
            end
        end
        return '0;
    endfunction

    initial begin
        rst = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        b_adv = 0; b_fl = 0; b_iv = 0; b_ird = 0; b_idv = 0; b_idata = 0;
        b_lv = 0; b_ldata = 0; b_sel = '0;

        // Outputs during reset
        #2;
        drive_a(1, 0, 1, 1, 1, 32'h1, 0, 0, 1, 2);
        #1;
        cmp("reset.fwd", {a_hit, a_pend, a_fdata}, '0);
        cmp("reset.commit", {a_cv, a_crd, a_cdata}, '0);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back dependency
        vt.push_back(row(1,0,1,1,1,32'hFFFFFFFF,0,0, 1,0, 2'b00,2'b00,0,0, 0,0,0));
        vt.push_back(row(1,0,0,0,0,0,0,0, 1,0, 2'b01,2'b00,32'hFFFFFFFF,0, 0,0,0));
        vt.push_back(row(1,0,0,0,0,0,0,0, 1,0, 2'b01,2'b00,32'hFFFFFFFF,0, 0,0,0));
        vt.push_back(row(1,0,0,0,0,0,0,0, 1,0, 2'b01,2'b00,32'hFFFFFFFF,0, 1,1,32'hFFFFFFFF));
        vt.push_back(row(1,0,0,0,0,0,0,0, 1,0, 2'b00,2'b00,0,0, 0,0,0));
        // Youngest wins, older commits first
        vt.push_back(row(1,0,1,5,1,32'h55,0,0, 5,5, 2'b00,2'b00,0,0, 0,0,0));
        vt.push_back(row(1,0,1,5,1,32'h77,0,0, 5,5, 2'b11,2'b00,32'h55,32'h55, 0,0,0));
        vt.push_back(row(0,0,0,0,0,0,0,0, 5,5, 2'b11,2'b00,32'h77,32'h77, 0,0,0));
        vt.push_back(row(1,0,0,0,0,0,0,0, 5,5, 2'b11,2'b00,32'h77,32'h77, 0,0,0));
        vt.push_back(row(1,0,0,0,0,0,0,0, 5,5, 2'b11,2'b00,32'h77,32'h77, 1,5,32'h55));
        vt.push_back(row(1,0,0,0,0,0,0,0, 5,5, 2'b11,2'b00,32'h77,32'h77, 1,5,32'h77));
        // Load-use with late fill while holding
        vt.push_back(row(1,0,1,3,0,32'hBAD,0,0, 3,0, 2'b00,2'b00,0,0, 0,0,0));
        vt.push_back(row(0,0,0,0,0,0,0,0, 3,0, 2'b01,2'b01,0,0, 0,0,0));
        vt.push_back(row(1,0,0,0,0,0,0,0, 3,0, 2'b01,2'b01,0,0, 0,0,0));
        vt.push_back(row(0,0,0,0,0,0,1,32'h1234, 3,0, 2'b01,2'b00,32'h1234,0, 0,0,0));
        vt.push_back(row(0,0,0,0,0,0,0,0, 3,0, 2'b01,2'b00,32'h1234,0, 0,0,0));
        vt.push_back(row(1,0,0,0,0,0,0,0, 3,0, 2'b01,2'b00,32'h1234,0, 0,0,0));
        vt.push_back(row(1,0,0,0,0,0,0,0, 3,0, 2'b01,2'b00,32'h1234,0, 1,3,32'h1234));
        // Late fill coinciding with advance
        vt.push_back(row(1,0,1,6,0,0,0,0, 6,0, 2'b00,2'b00,0,0, 0,0,0));
        vt.push_back(row(1,0,0,0,0,0,0,0, 6,0, 2'b01,2'b01,0,0, 0,0,0));
        vt.push_back(row(1,0,0,0,0,0,1,32'h66, 6,0, 2'b01,2'b00,32'h66,0, 0,0,0));
        vt.push_back(row(1,0,0,0,0,0,0,0, 6,0, 2'b01,2'b00,32'h66,0, 1,6,32'h66));
        // x0 and misses
        vt.push_back(row(1,0,1,0,1,32'hDEAD,0,0, 0,9, 2'b00,2'b00,0,0, 0,0,0));
        for (int k = 0; k < 3; k++)
            vt.push_back(row(1,0,0,0,0,0,0,0, 0,9, 2'b00,2'b00,0,0, 0,0,0));
        // Hold then flush
        vt.push_back(row(1,0,1,7,1,32'h70,0,0, 7,8, 2'b00,2'b00,0,0, 0,0,0));
        vt.push_back(row(1,0,1,8,1,32'h80,0,0, 7,8, 2'b01,2'b00,32'h70,0, 0,0,0));
        vt.push_back(row(1,0,1,9,1,32'h90,0,0, 7,8, 2'b11,2'b00,32'h70,32'h80, 0,0,0));
        for (int k = 0; k < 5; k++)
            vt.push_back(row(0,0,1,10,1,32'h99,0,0, 7,8, 2'b11,2'b00,32'h70,32'h80, 0,0,0));
        vt.push_back(row(1,1,1,10,1,32'hA0,0,0, 7,8, 2'b11,2'b00,32'h70,32'h80, 1,7,32'h70));
        for (int k = 0; k < 3; k++)
            vt.push_back(row(1,0,0,0,0,0,0,0, 8,9, 2'b00,2'b00,0,0, 0,0,0));

        foreach (vt[k]) begin
            drive_a(vt[k].adv, vt[k].fl, vt[k].iv, vt[k].ird, vt[k].idv, vt[k].idata,
                    vt[k].lv, vt[k].ldata, vt[k].s0, vt[k].s1);
            @(negedge clk);
            cmp($sformatf("tbl%0d.p0", k), {a_hit[0], a_pend[0], a_fdata[31:0]},
                {vt[k].hit[0], vt[k].pend[0], vt[k].d0});
            cmp($sformatf("tbl%0d.p1", k), {a_hit[1], a_pend[1], a_fdata[63:32]},
                {vt[k].hit[1], vt[k].pend[1], vt[k].d1});
            cmp($sformatf("tbl%0d.commit", k), {a_cv, a_crd, a_cdata},
                {vt[k].cv, vt[k].crd, vt[k].cdata});
            @(posedge clk); #1;
        end

        // Reset asserted mid-stream
        drive_a(1, 0, 1, 4, 1, 32'h41, 0, 0, 4, 0); @(posedge clk); #1;
        drive_a(1, 0, 1, 4, 1, 32'h42, 0, 0, 4, 0); @(posedge clk); #1;
        drive_a(1, 0, 1, 4, 1, 32'h43, 0, 0, 4, 0); @(posedge clk); #1;
        drive_a(1, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        @(negedge clk);
        cmp("rst_pre.p0", {a_hit[0], a_pend[0], a_fdata[31:0]}, {1'b1, 1'b0, 32'h43});
        cmp("rst_pre.commit", {a_cv, a_crd, a_cdata}, {1'b1, 5'd4, 32'h41});
        #1 rst = 1'b1;
        #1;
        cmp("rst_async.fwd", {a_hit, a_pend, a_fdata}, '0);
        cmp("rst_async.commit", {a_cv, a_crd, a_cdata}, '0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        cmp("rst_after.fwd", {a_hit, a_pend, a_fdata}, '0);
        cmp("rst_after.commit", {a_cv, a_crd, a_cdata}, '0);
        @(posedge clk); #1;

        // Randomized run against the model
        for (int i = 0; i < D; i++) begin
            mv[i] = 0; mrd[i] = 0; mdv[i] = 0; md[i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            logic adv, fl, iv, idv, lv;
            logic [4:0] ird, s0, s1;
            logic [31:0] idata, ldata;
            adv = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 19) == 0);
            iv = $urandom_range(0, 1) != 0;
            ird = 5'($urandom_range(0, 7));
            idv = ($urandom_range(0, 2) != 0);
            idata = $urandom;
            ldata = $urandom;
            s0 = 5'($urandom_range(0, 7));
            s1 = 5'($urandom_range(0, 7));
            // Loads must be resolved before leaving the late stage
            if (mv[L] && !mdv[L]) lv = (adv && !fl) ? 1'b1 : ($urandom_range(0, 1) != 0);
            else lv = 1'b0;
            drive_a(adv, fl, iv, ird, idv, idata, lv, ldata, s0, s1);
            @(negedge clk);
            cmp($sformatf("rnd%0d.p0", c), {a_hit[0], a_pend[0], a_fdata[31:0]},
                model_port(s0, lv, ldata));
            cmp($sformatf("rnd%0d.p1", c), {a_hit[1], a_pend[1], a_fdata[63:32]},
                model_port(s1, lv, ldata));
            cmp($sformatf("rnd%0d.commit", c), {a_cv, a_crd, a_cdata},
                (adv && mv[D-1]) ? {1'b1, mrd[D-1], md[D-1]} : 38'h0);
            if (lv && mv[L] && !mdv[L]) begin
                mdv[L] = 1'b1;
                md[L] = ldata;
            end
            if (fl) begin
                for (int i = 0; i < D; i++) begin
                    mv[i] = 0; mdv[i] = 0;
                end
            end else if (adv) begin
                for (int i = D - 1; i > 0; i--) begin
                    mv[i] = mv[i-1]; mrd[i] = mrd[i-1]; mdv[i] = mdv[i-1]; md[i] = md[i-1];
                end
                mv[0] = iv && (ird != 5'd0); mrd[0] = ird; mdv[0] = idv; md[0] = idata;
            end
            @(posedge clk); #1;
        end
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Parameter sweep on DUT B
        b_adv = 1; b_iv = 1; b_ird = 1; b_idv = 1; b_idata = 32'h11; @(posedge clk); #1;
        b_ird = 2; b_idv = 0; b_idata = 32'h0; @(posedge clk); #1;
        b_ird = 3; b_idv = 1; b_idata = 32'h33; @(posedge clk); #1;
        b_iv = 0; b_sel = {5'd3, 5'd2, 5'd1};
        @(negedge clk);
        cmp("sweep1.p0", {b_hit[0], b_pend[0], b_fdata[31:0]}, {1'b1, 1'b0, 32'h11});
        cmp("sweep1.p1", {b_hit[1], b_pend[1], b_fdata[63:32]}, {1'b1, 1'b1, 32'h0});
        cmp("sweep1.p2", {b_hit[2], b_pend[2], b_fdata[95:64]}, {1'b1, 1'b0, 32'h33});
        cmp("sweep1.commit", {b_cv, b_crd, b_cdata}, '0);
        @(posedge clk); #1;
        b_lv = 1; b_ldata = 32'h22;
        @(negedge clk);
        cmp("sweep2.p0", {b_hit[0], b_pend[0], b_fdata[31:0]}, {1'b1, 1'b0, 32'h11});
        cmp("sweep2.p1", {b_hit[1], b_pend[1], b_fdata[63:32]}, {1'b1, 1'b0, 32'h22});
        cmp("sweep2.p2", {b_hit[2], b_pend[2], b_fdata[95:64]}, {1'b1, 1'b0, 32'h33});
        cmp("sweep2.commit", {b_cv, b_crd, b_cdata}, {1'b1, 5'd1, 32'h11});
        @(posedge clk); #1;
        b_lv = 0; b_ldata = 0; b_adv = 0;
        @(negedge clk);
        cmp("sweep3.p0", {b_hit[0], b_pend[0], b_fdata[31:0]}, '0);
        cmp("sweep3.p1", {b_hit[1], b_pend[1], b_fdata[63:32]}, {1'b1, 1'b0, 32'h22});
        cmp("sweep3.p2", {b_hit[2], b_pend[2], b_fdata[95:64]}, {1'b1, 1'b0, 32'h33});
        cmp("sweep3.commit", {b_cv, b_crd, b_cdata}, '0);
        @(posedge clk); #1;
        b_adv = 1;
        @(negedge clk);
        cmp("sweep4.commit", {b_cv, b_crd, b_cdata}, {1'b1, 5'd2, 32'h22});
        @(posedge clk); #1;
        @(negedge clk);
        cmp("sweep5.commit", {b_cv, b_crd, b_cdata}, {1'b1, 5'd3, 32'h33});
        @(posedge clk); #1;
        b_adv = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
